// File: rtl/user_input_edge_bank.sv
// Multi-channel input conditioner: synchroniser, debounce,
// edge pulse and hold-to-repeat per channel.
module user_input_edge_bank #(
  parameter int N             = 4,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] in_i,
  input  logic [1:0]   mode_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] out_o
);

  localparam int DW = $clog2(DEBOUNCE < 2 ? 2 : DEBOUNCE);
  localparam int RMAX =
    REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX < 2 ? 2 : RMAX);
  localparam int DEB_T = DEBOUNCE - 1;
  localparam int RD_T = REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0;
  localparam int RP_T = REPEAT_PERIOD - 1;
  localparam bit REP_EN = REPEAT_DELAY > 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    REPT = 2'd2
  } rep_st_e;

  logic [N-1:0]  s1_q, s2_q;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  out_q, out_d;
  logic [DW-1:0] cnt_q [N];
  logic [DW-1:0] cnt_d [N];
  logic [RW-1:0] rep_q [N];
  logic [RW-1:0] rep_d [N];
  rep_st_e       st_q  [N];
  rep_st_e       st_d  [N];

  logic [N-1:0]  upd_w, ep_w, rp_w;
  logic          rep_ok;

  assign level_o = level_q;
  assign out_o   = out_q;

  // Two-flop synchroniser; idle-high so a held key gives no pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
    end
  end

  // Debounced level, pulse output and per-channel counters/states.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '1;
      out_q   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
        rep_q[i] <= '0;
        st_q[i]  <= IDLE;
      end
    end else begin
      level_q <= level_d;
      out_q   <= out_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
        rep_q[i] <= rep_d[i];
        st_q[i]  <= st_d[i];
      end
    end
  end

  // Debounce update, edge pulse select and repeat FSM next state.
  always_comb begin
    level_d = level_q;
    out_d   = '0;
    upd_w   = '0;
    ep_w    = '0;
    rp_w    = '0;
    rep_ok  = REP_EN && (mode_i == 2'b00 || mode_i == 2'b10);
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      rep_d[i] = rep_q[i];
      st_d[i]  = st_q[i];

      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DW'(DEB_T)) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
        upd_w[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end

      ep_w[i] = upd_w[i] &
                ((mode_i == 2'b00 & s2_q[i]) |
                 (mode_i == 2'b01 & ~s2_q[i]) |
                 (mode_i == 2'b10));

      // Judge repeat on the next level so a falling update never repeats.
      if (!rep_ok || !level_d[i]) begin
        st_d[i]  = IDLE;
        rep_d[i] = '0;
      end else begin
        unique case (st_q[i])
          IDLE: begin
            if (upd_w[i]) begin
              st_d[i]  = HOLD;
              rep_d[i] = '0;
            end
          end
          HOLD: begin
            if (rep_q[i] == RW'(RD_T)) begin
              rp_w[i]  = 1'b1;
              st_d[i]  = REPT;
              rep_d[i] = '0;
            end else begin
              rep_d[i] = rep_q[i] + RW'(1);
            end
          end
          REPT: begin
            if (rep_q[i] == RW'(RP_T)) begin
              rp_w[i]  = 1'b1;
              rep_d[i] = '0;
            end else begin
              rep_d[i] = rep_q[i] + RW'(1);
            end
          end
          default: begin
            st_d[i]  = IDLE;
            rep_d[i] = '0;
          end
        endcase
      end

      out_d[i] = ep_w[i] | rp_w[i];
    end
  end

endmodule

// File: tb/tb_user_input_edge_bank.sv
// Randomised and directed bench for user_input_edge_bank
// against a window-based behavioural model.
module tb_user_input_edge_bank;

  localparam int D = 8;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] in_i = 4'hF;
  logic [1:0] mode_i = 2'b00;
  logic [3:0] level_o, out_o;

  int n_cmp = 0;
  int n_bad = 0;

  user_input_edge_bank #(
    .N(4), .DEBOUNCE(4), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .in_i(in_i), .mode_i(mode_i),
    .level_o(level_o), .out_o(out_o)
  );

  always #5 clk = ~clk;

  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
  logic [3:0] m_level = 4'hF, m_out = 4'h0;
  logic [3:0] m_hist [4];
  bit         m_armed [4];
  int         m_age [4];
  bit         m_up, m_nl, m_ep, m_rp;

  // Model: a level flips once the last four synced samples all
  // disagree with it; repeats follow hold age since the rise.
  always @(posedge clk) begin
    if (rst_i) begin
      m_s1 = 4'hF; m_s2 = 4'hF;
      m_level = 4'hF; m_out = 4'h0;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = 4'hF; m_armed[i] = 0; m_age[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][2:0], m_s2[i]};
        m_up = (m_hist[i] == {4{~m_level[i]}});
        m_nl = m_up ? ~m_level[i] : m_level[i];
        m_ep = m_up && ((mode_i == 2'd0 && m_nl) ||
                        (mode_i == 2'd1 && !m_nl) ||
                        (mode_i == 2'd2));
        m_rp = 0;
        if (mode_i == 2'd1 || mode_i == 2'd3 || !m_nl) begin
          m_armed[i] = 0;
        end else if (m_up) begin
          m_armed[i] = 1; m_age[i] = 0;
        end else if (m_armed[i]) begin
          m_age[i]++;
          m_rp = (m_age[i] == D) ||
                 (m_age[i] > D && (m_age[i] - D) % P == 0);
        end
        m_out[i] = m_ep | m_rp;
        m_level[i] = m_nl;
      end
      m_s2 = m_s1;
      m_s1 = in_i;
    end
  end

  task automatic test_reset();
    rst_i = 1'b1; in_i = 4'hF; mode_i = 2'b00;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== 4'hF || out_o !== 4'h0) begin
        n_bad++;
        $display("FAIL reset_state: level=%h out=%h want F/0",
                 level_o, out_o);
      end
    end
    rst_i = 1'b0;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== 4'hF || out_o !== 4'h0) begin
        n_bad++;
        $display("FAIL reset_hold: level=%h out=%h want F/0",
                 level_o, out_o);
      end
    end
  endtask

  task automatic test_fall();
    int at = -1;
    int np = 0;
    mode_i = 2'b01; in_i = 4'hE;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== m_level || out_o !== m_out) begin
        n_bad++;
        $display("FAIL fall_model: level=%h out=%h want %h/%h",
                 level_o, out_o, m_level, m_out);
      end
      if (out_o == 4'b0001) at = k;
    end
    n_cmp++;
    if (at !== 6 || level_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL fall_pulse: at=%0d lvl0=%b want 6/0",
               at, level_o[0]);
    end
    in_i = 4'hF;
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== m_level || out_o !== m_out) begin
        n_bad++;
        $display("FAIL fall_back: level=%h out=%h want %h/%h",
                 level_o, out_o, m_level, m_out);
      end
      if (out_o != 4'h0) np++;
    end
    n_cmp++;
    if (np !== 0 || level_o !== 4'hF) begin
      n_bad++;
      $display("FAIL fall_rise_quiet: pulses=%0d level=%h want 0/F",
               np, level_o);
    end
  endtask

  task automatic test_bounce();
    mode_i = 2'b00;
    for (int c = 0; c < 12; c++) begin
      in_i[1] = ((c / 2) % 2 == 1);
      @(negedge clk);
      n_cmp++;
      if (level_o !== m_level || out_o !== m_out ||
          out_o[1] !== 1'b0 || level_o[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL bounce: level=%h out=%h want %h/%h",
                 level_o, out_o, m_level, m_out);
      end
    end
    in_i[1] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== m_level || out_o[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce_settle: level=%h out=%h want %h/0",
                 level_o, out_o, m_level);
      end
    end
    n_cmp++;
    if (level_o[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce_final: lvl1=%b want 0", level_o[1]);
    end
    mode_i = 2'b11; in_i = 4'hF;
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (out_o !== 4'h0 || level_o !== m_level) begin
        n_bad++;
        $display("FAIL mode_off: level=%h out=%h want %h/0",
                 level_o, out_o, m_level);
      end
    end
  endtask

  task automatic test_both();
    logic [3:0] pat [2];
    int good, bad;
    pat[0] = 4'h3; pat[1] = 4'hF;
    mode_i = 2'b10;
    for (int t = 0; t < 2; t++) begin
      good = 0; bad = 0;
      in_i = pat[t];
      repeat (8) begin
        @(negedge clk);
        n_cmp++;
        if (level_o !== m_level || out_o !== m_out) begin
          n_bad++;
          $display("FAIL both_model: level=%h out=%h want %h/%h",
                   level_o, out_o, m_level, m_out);
        end
        if (out_o == 4'b1100) good++;
        else if (out_o != 4'h0) bad++;
      end
      n_cmp++;
      if (good !== 1 || bad !== 0) begin
        n_bad++;
        $display("FAIL both_pulse: t=%0d good=%0d bad=%0d want 1/0",
                 t, good, bad);
      end
    end
  endtask

  task automatic test_repeat();
    int np = 0;
    bit low = 0;
    mode_i = 2'b11; in_i = 4'hB;
    repeat (10) @(negedge clk);
    mode_i = 2'b00; in_i = 4'hF;
    repeat (36) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== m_level || out_o !== m_out ||
          (out_o & 4'b1011) !== 4'h0) begin
        n_bad++;
        $display("FAIL repeat_model: level=%h out=%h want %h/%h",
                 level_o, out_o, m_level, m_out);
      end
      if (out_o[2]) np++;
    end
    n_cmp++;
    if (np !== 7) begin
      n_bad++;
      $display("FAIL repeat_count: pulses=%0d want 7", np);
    end
    in_i = 4'hB;
    repeat (15) begin
      @(negedge clk);
      if (level_o[2] == 1'b0) low = 1;
      n_cmp++;
      if (level_o !== m_level || out_o !== m_out ||
          (low && out_o[2])) begin
        n_bad++;
        $display("FAIL repeat_release: level=%h out=%h want %h/%h",
                 level_o, out_o, m_level, m_out);
      end
    end
    n_cmp++;
    if (!low) begin
      n_bad++;
      $display("FAIL repeat_low: lvl2=%b want 0", level_o[2]);
    end
  endtask

  task automatic test_reset_mid();
    int nf = 0;
    mode_i = 2'b00; in_i = 4'hF;
    repeat (12) @(negedge clk);
    in_i = 4'h0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (level_o !== 4'hF || out_o !== 4'h0) begin
      n_bad++;
      $display("FAIL mid_reset: level=%h out=%h want F/0",
               level_o, out_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (level_o !== 4'hF || out_o !== 4'h0) begin
      n_bad++;
      $display("FAIL mid_release: level=%h out=%h want F/0",
               level_o, out_o);
    end
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== m_level || out_o !== 4'h0) begin
        n_bad++;
        $display("FAIL mid_fall: level=%h out=%h want %h/0",
                 level_o, out_o, m_level);
      end
    end
    in_i = 4'hF;
    repeat (8) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== m_level || out_o !== m_out) begin
        n_bad++;
        $display("FAIL mid_rise: level=%h out=%h want %h/%h",
                 level_o, out_o, m_level, m_out);
      end
      if (out_o == 4'hF) nf++;
    end
    n_cmp++;
    if (nf !== 1) begin
      n_bad++;
      $display("FAIL mid_all: pulses=%0d want 1", nf);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== m_level || out_o !== m_out) begin
        n_bad++;
        $display("FAIL random c=%0d: level=%h out=%h want %h/%h",
                 c, level_o, out_o, m_level, m_out);
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) in_i[b] = ~in_i[b];
      if ($urandom_range(0, 49) == 0)
        mode_i = 2'($urandom_range(0, 3));
      rst_i = ($urandom_range(0, 299) == 0);
    end
    rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = 4'hF; m_armed[i] = 0; m_age[i] = 0;
    end
    test_reset();
    test_fall();
    test_bounce();
    test_both();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
